// File: rtl/ama_riscv_mem_arb_pkg.sv
// rtl/ama_riscv_mem_arb_pkg.sv - shared memory-system defines and state types
package ama_riscv_mem_arb_pkg;

    localparam int MEM_ADDR_BUS         = 12;
    localparam int MEM_DATA_BUS         = 128;
    localparam int MEM_TRANSFERS_PER_CL = 4;

    typedef enum logic [1:0] {
        CACHE_IDLE,
        CACHE_LOOKUP,
        CACHE_MISS,
        CACHE_WRITEBACK
    } cache_state_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } mem_arb_state_t;

    typedef enum logic {
        OWNER_IC,
        OWNER_DC
    } mem_arb_owner_t;

endpackage

// File: rtl/ama_riscv_mem_arb_if.sv
// rtl/ama_riscv_mem_arb_if.sv - cache line ports and main-memory beat port of the arbiter
interface ama_riscv_mem_arb_if
    import ama_riscv_mem_arb_pkg::*;
#(
    parameter int AW    = MEM_ADDR_BUS,
    parameter int DW    = MEM_DATA_BUS,
    parameter int BEATS = MEM_TRANSFERS_PER_CL
);
    // icache line-read port
    logic                ic_req_valid;
    logic                ic_req_ready;
    logic [AW-1:0]       ic_req_addr;
    logic                ic_rsp_valid;
    logic [DW-1:0]       ic_rsp_data;
    logic                ic_rsp_last;

    // dcache refill / writeback port
    logic                dc_req_valid;
    logic                dc_req_ready;
    logic                dc_req_we;
    logic [AW-1:0]       dc_req_addr;
    logic [DW*BEATS-1:0] dc_req_wdata;
    logic                dc_rsp_valid;
    logic [DW-1:0]       dc_rsp_data;
    logic                dc_rsp_last;

    // main-memory beat port
    logic                mem_req_valid;
    logic                mem_req_ready;
    logic                mem_req_we;
    logic [AW-1:0]       mem_req_addr;
    logic [DW-1:0]       mem_req_wdata;
    logic                mem_rsp_valid;
    logic [DW-1:0]       mem_rsp_data;

    // arbiter side
    modport master (
        input  ic_req_valid, ic_req_addr,
        output ic_req_ready, ic_rsp_valid, ic_rsp_data, ic_rsp_last,
        input  dc_req_valid, dc_req_we, dc_req_addr, dc_req_wdata,
        output dc_req_ready, dc_rsp_valid, dc_rsp_data, dc_rsp_last,
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

    // caches + memory side
    modport slave (
        output ic_req_valid, ic_req_addr,
        input  ic_req_ready, ic_rsp_valid, ic_rsp_data, ic_rsp_last,
        output dc_req_valid, dc_req_we, dc_req_addr, dc_req_wdata,
        input  dc_req_ready, dc_rsp_valid, dc_rsp_data, dc_rsp_last,
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data
    );

endinterface

// File: rtl/ama_riscv_mem_arb.sv
// rtl/ama_riscv_mem_arb.sv - round-robin icache/dcache line arbiter onto the main-memory beat port
module ama_riscv_mem_arb
    import ama_riscv_mem_arb_pkg::*;
#(
    parameter int AW    = MEM_ADDR_BUS,
    parameter int DW    = MEM_DATA_BUS,
    parameter int BEATS = MEM_TRANSFERS_PER_CL
)(
    input  logic                 clk,
    input  logic                 rst,
    ama_riscv_mem_arb_if.master  bus
);

    localparam int CW = $clog2(BEATS);

    // DC wins only when it is the sole requester or it is its turn
    function automatic logic pick_dc(input logic ic_v, input logic dc_v, input logic dc_first);
        return dc_v && (!ic_v || dc_first);
    endfunction

    mem_arb_state_t      state;
    mem_arb_state_t      state_nxt;
    mem_arb_owner_t      owner;
    logic                we;
    logic [AW-1:0]       base_addr;
    logic [DW*BEATS-1:0] line_buf;
    logic [CW-1:0]       req_cnt;
    logic [CW-1:0]       rsp_cnt;
    logic                rr_dc_first;

    logic                grant_ic;
    logic                grant_dc;
    logic                req_hs;
    logic                req_last;
    logic                rsp_fire;
    logic                rsp_last;

    // offset bits of the line addresses are dropped by alignment
    logic                unused_addr_lsb;
    assign unused_addr_lsb = ^{bus.ic_req_addr[CW-1:0], bus.dc_req_addr[CW-1:0]};

    assign req_hs   = (state == ISSUE) && bus.mem_req_ready;
    assign req_last = (req_cnt == CW'(BEATS - 1));
    // responses are only meaningful for reads; anything else on the return bus is dropped
    assign rsp_fire = ((state == ISSUE) || (state == DRAIN)) && !we && bus.mem_rsp_valid;
    assign rsp_last = (rsp_cnt == CW'(BEATS - 1));

    // grant decision, only in IDLE and never while reset is held
    always_comb begin
        grant_dc = 1'b0;
        grant_ic = 1'b0;
        if ((state == IDLE) && !rst) begin
            grant_dc = pick_dc(bus.ic_req_valid, bus.dc_req_valid, rr_dc_first);
            grant_ic = bus.ic_req_valid && !grant_dc;
        end
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (grant_ic || grant_dc) state_nxt = ISSUE;
            ISSUE:   if (req_hs && req_last)   state_nxt = we ? IDLE : DRAIN;
            DRAIN:   if (rsp_fire && rsp_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // transaction context: captured on grant, counters advance per beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner       <= OWNER_IC;
            we          <= 1'b0;
            base_addr   <= '0;
            line_buf    <= '0;
            req_cnt     <= '0;
            rsp_cnt     <= '0;
            rr_dc_first <= 1'b1;
        end else if (grant_ic || grant_dc) begin
            owner       <= grant_dc ? OWNER_DC : OWNER_IC;
            we          <= grant_dc && bus.dc_req_we;
            base_addr   <= grant_dc ? {bus.dc_req_addr[AW-1:CW], {CW{1'b0}}}
                                    : {bus.ic_req_addr[AW-1:CW], {CW{1'b0}}};
            line_buf    <= (grant_dc && bus.dc_req_we) ? bus.dc_req_wdata : '0;
            req_cnt     <= '0;
            rsp_cnt     <= '0;
            rr_dc_first <= !grant_dc;
        end else begin
            if (req_hs) begin
                req_cnt <= req_cnt + 1'b1;
            end
            if (rsp_fire) begin
                rsp_cnt <= rsp_cnt + 1'b1;
            end
        end
    end

    // outputs: readies, memory beat request, response routing to the owner
    always_comb begin
        bus.ic_req_ready  = grant_ic;
        bus.dc_req_ready  = grant_dc;

        bus.mem_req_valid = (state == ISSUE);
        bus.mem_req_we    = (state == ISSUE) && we;
        bus.mem_req_addr  = '0;
        bus.mem_req_wdata = '0;
        if (state == ISSUE) begin
            bus.mem_req_addr = base_addr | AW'(req_cnt);
            if (we) begin
                bus.mem_req_wdata = line_buf[int'(req_cnt)*DW +: DW];
            end
        end

        bus.ic_rsp_valid  = rsp_fire && (owner == OWNER_IC);
        bus.ic_rsp_data   = bus.ic_rsp_valid ? bus.mem_rsp_data : '0;
        bus.ic_rsp_last   = bus.ic_rsp_valid && rsp_last;

        bus.dc_rsp_valid  = rsp_fire && (owner == OWNER_DC);
        bus.dc_rsp_data   = bus.dc_rsp_valid ? bus.mem_rsp_data : '0;
        bus.dc_rsp_last   = bus.dc_rsp_valid && rsp_last;
    end

endmodule

// File: doc/ama_riscv_mem_arb.md
# ama_riscv_mem_arb

Two-client cache-line memory arbiter between the instruction cache and data cache refill/writeback ports and the single 128-bit main-memory port. It accepts one whole-line request at a time from either cache and serializes it into `MEM_TRANSFERS_PER_CL` (4) memory beats. Read responses are routed back to the owning cache with a last-beat marker. Round-robin arbitration prevents either cache from starving the other.

## Interface
- `AW`, default `MEM_ADDR_BUS` (12): memory beat address width, in 128-bit units.
- `DW`, default `MEM_DATA_BUS` (128): memory beat width.
- `BEATS`, default `MEM_TRANSFERS_PER_CL` (4): beats per cache line; must be a power of 2.
- `clk` in 1: the only clock.
- `rst` in 1: reset, asynchronous and active-high.
- `ic_req_valid` in 1: icache line-read request.
- `ic_req_ready` out 1: request accepted this cycle.
- `ic_req_addr` in AW: line address; low log2(BEATS) bits ignored.
- `ic_rsp_valid` out 1: read beat for icache.
- `ic_rsp_data` out DW: beat data.
- `ic_rsp_last` out 1: final beat of line.
- `dc_req_valid` in 1: dcache line request.
- `dc_req_ready` out 1: request accepted this cycle.
- `dc_req_we` in 1: 1 = writeback, 0 = refill.
- `dc_req_addr` in AW: line address; low bits ignored.
- `dc_req_wdata` in DW*BEATS: full line for writeback; beat k = bits [DW*k +: DW].
- `dc_rsp_valid`, `dc_rsp_data`, `dc_rsp_last`: out 1 / DW / 1; same meaning as icache.
- `mem_req_valid` out 1: memory beat request.
- `mem_req_ready` in 1: memory accepts beat.
- `mem_req_we` out 1: write beat.
- `mem_req_addr` out AW: beat address.
- `mem_req_wdata` out DW: write beat data.
- `mem_rsp_valid` in 1: read beat return; in order; no backpressure; at least 1 cycle after the matching request handshake.
- `mem_rsp_data` in DW: read beat data.

## Operation
- FSM states `IDLE`, `ISSUE`, `DRAIN`. Registers: `owner` (IC/DC), `we`, `base_addr`, line buffer (DW*BEATS), `req_cnt`, `rsp_cnt` (log2(BEATS) bits each), `rr_dc_first`.
- **IDLE:**
  - Grant goes to the single valid client.
  - If both clients are valid, grant the DC when `rr_dc_first`=1, otherwise the IC.
  - Grant asserts that client's `*_req_ready` combinationally in the same cycle.
  - On grant, capture owner, we (forced 0 for IC), `{addr[AW-1:log2 BEATS], 0}`, and wdata.
  - On grant, clear both counters, set `rr_dc_first` = (owner==IC), and move to `ISSUE`.
  - `*_req_ready` is 0 in every state other than `IDLE`.
- **ISSUE:**
  - `mem_req_valid`=1, `mem_req_addr` = base | `req_cnt`, `mem_req_wdata` = beat `req_cnt` (0 for reads).
  - On `mem_req_valid && mem_req_ready`, increment `req_cnt`.
  - On the last-beat handshake: for a write, go to `IDLE`; for a read, go to `DRAIN`.
- **Responses** (in `ISSUE` or `DRAIN`, read transactions only):
  - `mem_rsp_valid` drives the owner's `*_rsp_valid` combinationally, with data passed through.
  - `*_rsp_last` = (`rsp_cnt`==BEATS-1).
  - Each response beat increments `rsp_cnt`.
- **DRAIN:** `mem_req_valid`=0; go to `IDLE` on the cycle the last response beat is delivered.
- `mem_rsp_valid` in `IDLE`, or during a write transaction, is dropped and is never forwarded.
- Only one line transaction is in flight at a time. A new grant is possible only in `IDLE`.

## Timing
- **Reset values:**
  - State `IDLE`, `rr_dc_first`=1, counters 0, buffer 0.
  - All `*_valid`, `*_ready`, `*_last`, and `mem_req_we` are 0; `mem_req_addr` and `mem_req_wdata` are 0.
  - Readies are gated off while `rst` is high.
- **Grant at cycle T:**
  - First `mem_req_valid` at T+1.
  - With `mem_req_ready` tied 1, beats are issued at T+1..T+4.
  - A write returns to `IDLE` at T+5; the next grant is possible at T+5.
- **Read with memory latency L:** the last response arrives at T+4+L; `IDLE` and the next grant follow the cycle after.
- `mem_req_ready` low stalls `req_cnt`; address and data are held stable while valid is high.
- A response in the same cycle as a request handshake updates both counters independently.
- Counters wrap from BEATS-1 to 0 only on transaction completion, never mid-line.
- Reset asserted mid-transaction aborts immediately to reset values; a partial line is neither completed nor retried.

## Structure
- Add `mem_arb_state_t` (`IDLE`/`ISSUE`/`DRAIN`) to the shared defines package, next to `cache_state_t`.
- Reuse `MEM_ADDR_BUS`, `MEM_DATA_BUS`, and `MEM_TRANSFERS_PER_CL`.
- No sub-module. The round-robin pick is a small function inside the block.

## Test plan
- **IC read, memory ready=1, L=2:** `ic_req_addr`=0x123 → `mem_req_addr` 0x120..0x123 at T+1..T+4; `ic_rsp_valid` at T+3..T+6; `ic_rsp_last` only at T+6; `ic_req_ready` back in `IDLE` at T+7.
- **DC write, addr 0x040, wdata beat k = 0xA0+k:** 4 write beats, addr 0x040..0x043, data 0xA0..0xA3; no `dc_rsp_valid`; `IDLE` at T+5.
- **Simultaneous IC and DC valid, repeated:** first grant DC, then IC, then DC (alternating); neither client waits more than one transaction.
- **`mem_req_ready` low for 3 cycles on beat 2:** addr and data held; total issue takes 7 cycles; the beat sequence is unchanged.
- **Stray `mem_rsp_valid` in `IDLE` and during a DC write:** no `*_rsp_valid` asserted; counters unchanged.
- **Reset asserted after 2 beats of an IC read:** all outputs 0 immediately; after release, a new DC request is granted first (`rr_dc_first`=1).
